// File: rtl/unitary_decoder_pipe.sv
// unitary_decoder_pipe: two-stage one-hot selector to binary index decoder with hit/multi flags and multi-hit counter.
module unitary_decoder_pipe #(
    parameter int INPUT_WIDTH = 3,
    parameter int CNT_WIDTH = 8,
    localparam int SEL_WIDTH = 2 ** INPUT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_WIDTH-1:0]   in_selector,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INPUT_WIDTH-1:0] out_addr,
    output logic                   out_hit,
    output logic                   out_multi,
    input  logic                   err_clear,
    output logic [CNT_WIDTH-1:0]   err_count
);
    logic                   s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [SEL_WIDTH-1:0]   s1_sel_q, s1_sel_d;
    logic [INPUT_WIDTH-1:0] addr_q, addr_d, dec_addr;
    logic                   hit_q, hit_d, multi_q, multi_d, dec_hit, dec_multi;
    logic [CNT_WIDTH-1:0]   err_q, err_d;
    logic                   s1_en, s2_en, s2_load;

    // Scan downward so the lowest set bit wins.
    always_comb begin
        dec_addr = '0;
        for (int i = SEL_WIDTH - 1; i >= 0; i--)
            if (s1_sel_q[i]) dec_addr = INPUT_WIDTH'(i);
        dec_hit = |s1_sel_q;
        dec_multi = (s1_sel_q & (s1_sel_q - SEL_WIDTH'(1))) != '0;
    end

    always_comb begin
        s2_en = !s2_valid_q || out_ready;
        s1_en = !s1_valid_q || s2_en;
        s2_load = s2_en && s1_valid_q;
        s1_valid_d = s1_en ? in_valid : s1_valid_q;
        s1_sel_d = (s1_en && in_valid) ? in_selector : s1_sel_q;
        s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
        addr_d = s2_load ? dec_addr : addr_q;
        hit_d = s2_load ? dec_hit : hit_q;
        multi_d = s2_load ? dec_multi : multi_q;
        err_d = err_clear ? '0
              : (s2_valid_q && out_ready && multi_q && err_q != '1) ? err_q + CNT_WIDTH'(1)
              : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_sel_q <= '0;
            addr_q <= '0;
            hit_q <= 1'b0;
            multi_q <= 1'b0;
            err_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_sel_q <= s1_sel_d;
            addr_q <= addr_d;
            hit_q <= hit_d;
            multi_q <= multi_d;
            err_q <= err_d;
        end
    end

    assign in_ready = s1_en;
    assign out_valid = s2_valid_q;
    assign out_addr = addr_q;
    assign out_hit = hit_q;
    assign out_multi = multi_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_unitary_decoder_pipe.sv
// tb_unitary_decoder_pipe: directed plus random traffic against a queue-based reference model, two counter widths.
module tb_unitary_decoder_pipe;
    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0, err_clear = 1'b0;
    logic [7:0] in_selector = '0;
    logic       in_ready, out_valid, out_hit, out_multi;
    logic [2:0] out_addr;
    logic [7:0] err_count;
    logic       in_ready_b, out_valid_b, out_hit_b, out_multi_b;
    logic [2:0] out_addr_b;
    logic [1:0] err_count_b;

    int total = 0, bad = 0, cyc_n = 0;
    logic [7:0] sel_q[$];
    int         acc_q[$];
    int         m8 = 0, m2 = 0;
    logic       prev_stall = 1'b0, p_hit, p_multi;
    logic [2:0] p_addr;

    always #5 clk = ~clk;

    unitary_decoder_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_selector(in_selector),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_hit(out_hit),
        .out_multi(out_multi), .err_clear(err_clear), .err_count(err_count)
    );

    unitary_decoder_pipe #(.CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_selector(in_selector),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_addr(out_addr_b), .out_hit(out_hit_b),
        .out_multi(out_multi_b), .err_clear(err_clear), .err_count(err_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic int ones(input logic [7:0] s);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(s[i]);
        return n;
    endfunction

    function automatic logic [2:0] lowest(input logic [7:0] s);
        for (int i = 0; i < 8; i++) if (s[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic cyc(input logic iv, input logic [7:0] s, input logic ordy, input logic clr, output logic acc);
        logic exp_ov, del, mul;
        @(negedge clk);
        in_valid = iv; in_selector = s; out_ready = ordy; err_clear = clr;
        #1;
        chk("in_ready", in_ready, !(sel_q.size() == 2 && !ordy));
        chk("in_ready_b", in_ready_b, !(sel_q.size() == 2 && !ordy));
        exp_ov = sel_q.size() > 0 && acc_q[0] <= cyc_n - 2;
        chk("out_valid", out_valid, exp_ov);
        chk("out_valid_b", out_valid_b, exp_ov);
        if (prev_stall) begin
            chk("hold_addr", out_addr, p_addr);
            chk("hold_hit", out_hit, p_hit);
            chk("hold_multi", out_multi, p_multi);
        end
        if (exp_ov) begin
            chk("addr", out_addr, lowest(sel_q[0]));
            chk("hit", out_hit, sel_q[0] != 0);
            chk("multi", out_multi, ones(sel_q[0]) > 1);
            chk("addr_b", out_addr_b, lowest(sel_q[0]));
            chk("multi_b", out_multi_b, ones(sel_q[0]) > 1);
        end
        chk("err8", err_count, m8);
        chk("err2", err_count_b, m2);
        del = exp_ov && ordy;
        mul = del && ones(sel_q[0]) > 1;
        acc = iv && !(sel_q.size() == 2 && !ordy);
        if (del) begin
            void'(sel_q.pop_front());
            void'(acc_q.pop_front());
        end
        m8 = clr ? 0 : (mul && m8 < 255) ? m8 + 1 : m8;
        m2 = clr ? 0 : (mul && m2 < 3) ? m2 + 1 : m2;
        if (acc) begin
            sel_q.push_back(s);
            acc_q.push_back(cyc_n);
        end
        prev_stall = out_valid && !ordy;
        p_addr = out_addr; p_hit = out_hit; p_multi = out_multi;
        cyc_n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; err_clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sel_q.delete(); acc_q.delete();
        m8 = 0; m2 = 0; prev_stall = 1'b0;
    endtask

    initial begin
        logic a;
        logic [7:0] burst[4] = '{8'h04, 8'h30, 8'h00, 8'h81};
        int sent;
        do_reset();
        #1;
        chk("rst_addr", out_addr, 0);
        chk("rst_hit", out_hit, 0);
        chk("rst_multi", out_multi, 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'(1 << i), 1, 0, a);
        cyc(1, 8'h00, 1, 0, a);
        cyc(1, 8'hA0, 1, 0, a);
        cyc(1, 8'hFF, 1, 0, a);
        for (int i = 0; i < 4; i++) cyc(0, 8'h5A, 1, 0, a);
        sent = 0;
        for (int t = 0; t < 14; t++) begin
            cyc(sent < 4, sent < 4 ? burst[sent] : 8'h00, t >= 7, 0, a);
            if (a) sent++;
        end
        chk("burst_sent", sent, 4);
        for (int i = 0; i < 5; i++) cyc(1, 8'hC3, 1, 0, a);
        cyc(0, 8'h00, 1, 0, a);
        cyc(0, 8'h00, 1, 1, a);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, a);
        cyc(1, 8'h11, 1, 0, a);
        cyc(1, 8'h22, 1, 0, a);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, a);
        for (int t = 0; t < 3000; t++) begin
            int k = $urandom_range(0, 3);
            logic [7:0] s = k == 0 ? 8'h00 : k == 1 ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            cyc($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0, a);
            if ($urandom_range(0, 700) == 0) do_reset();
        end
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, a);
        chk("drained", sel_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
